// File: rtl/base_acredit_pkg.sv
// Shared constants and helpers for the multi-channel credit source.
// Imported by the arbiter and the top-level wrapper.
package base_acredit_pkg;

  localparam int rst_ptr = 0;

  function automatic int chid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/base_incdec.sv
// Up/down counter with load; a simultaneous increment and decrement cancel.
module base_incdec #(
  parameter int               width = 3,
  parameter logic [width-1:0] rstv  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_set_v,
  input  logic [width-1:0] i_set_d,
  input  logic             i_inc,
  input  logic             i_dec,
  output logic [width-1:0] o_cnt
);

  always_ff @(posedge clk) begin
    if (reset)
      o_cnt <= rstv;
    else if (i_set_v)
      o_cnt <= i_set_d;
    else if (i_inc && !i_dec)
      o_cnt <= o_cnt + width'(1);
    else if (i_dec && !i_inc)
      o_cnt <= o_cnt - width'(1);
  end

endmodule

// File: rtl/base_rr_arb.sv
// Round-robin arbiter: grants the first request at or after the pointer,
// and moves the pointer past the winner when the grant is accepted.
module base_rr_arb
  import base_acredit_pkg::*;
#(
  parameter int ways = 2,
  parameter int id_w = chid_width(ways)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [ways-1:0] i_req,
  input  logic            i_adv,
  output logic            o_v,
  output logic [ways-1:0] o_gnt,
  output logic [id_w-1:0] o_id
);

  logic [id_w-1:0] ptr;
  logic            found;
  int              idx;

  assign o_v = |i_req;

  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    found = 1'b0;
    idx   = 0;
    for (int i = 0; i < ways; i++) begin
      idx = int'(ptr) + i;
      if (idx >= ways)
        idx = idx - ways;
      if (!found && i_req[id_w'(idx)]) begin
        found              = 1'b1;
        o_gnt[id_w'(idx)]  = 1'b1;
        o_id               = id_w'(idx);
      end
    end
  end

  // Pointer only moves on an accepted grant so a stalled grant stays put.
  always_ff @(posedge clk) begin
    if (reset)
      ptr <= id_w'(rst_ptr);
    else if (i_adv && o_v)
      ptr <= (int'(o_id) == ways - 1) ? '0 : o_id + id_w'(1);
  end

endmodule

// File: rtl/base_vlat.sv
// One-cycle register stage cleared by reset.
module base_vlat #(
  parameter int width = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] i_d,
  output logic [width-1:0] o_d
);

  always_ff @(posedge clk) begin
    if (reset)
      o_d <= '0;
    else
      o_d <= i_d;
  end

endmodule

// File: rtl/base_acredit_mc_src.sv
// Multi-channel credit source: per-channel credit counters feeding a
// round-robin merge onto one valid/ready output.
module base_acredit_mc_src
  import base_acredit_pkg::*;
#(
  parameter int channels    = 2,
  parameter int width       = 8,
  parameter int credits     = 4,
  parameter int log_credits = $clog2(credits + 1),
  parameter int chid_w      = chid_width(channels)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [channels-1:0]             i_v,
  output logic [channels-1:0]             i_r,
  input  logic [channels*width-1:0]       i_d,
  input  logic [channels-1:0]             o_c,
  input  logic                            o_r,
  output logic                            o_v,
  output logic [width-1:0]                o_d,
  output logic [chid_w-1:0]               o_ch,
  output logic [channels*log_credits-1:0] o_cnt,
  output logic                            o_idle,
  output logic                            o_err
);

  localparam logic [log_credits-1:0] cmax = log_credits'(credits);

  logic [channels-1:0]    s1_c, elig, gnt, xfer, full, inc, ovf;
  logic [log_credits-1:0] cnt [channels];
  logic                   arb_v;
  logic [chid_w-1:0]      gnt_id;

  base_vlat #(.width(channels)) u_lat (
    .clk   (clk),
    .reset (reset),
    .i_d   (o_c),
    .o_d   (s1_c)
  );

  // A returned credit on a full counter is dropped unless a beat leaves the same cycle.
  for (genvar k = 0; k < channels; k++) begin : g_ch
    assign elig[k] = i_v[k] & (cnt[k] != '0);
    assign full[k] = (cnt[k] == cmax);
    assign ovf[k]  = s1_c[k] & full[k] & ~xfer[k];
    assign inc[k]  = s1_c[k] & ~ovf[k];
    assign o_cnt[k*log_credits +: log_credits] = cnt[k];

    base_incdec #(.width(log_credits), .rstv(cmax)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .i_set_v (1'b0),
      .i_set_d ('0),
      .i_inc   (inc[k]),
      .i_dec   (xfer[k]),
      .o_cnt   (cnt[k])
    );
  end

  base_rr_arb #(.ways(channels), .id_w(chid_w)) u_arb (
    .clk   (clk),
    .reset (reset),
    .i_req (elig),
    .i_adv (o_r),
    .o_v   (arb_v),
    .o_gnt (gnt),
    .o_id  (gnt_id)
  );

  assign o_v    = arb_v;
  assign o_ch   = gnt_id;
  assign i_r    = gnt & {channels{o_r}};
  assign xfer   = i_v & i_r;
  assign o_idle = (&full) & ~(|s1_c);

  always_comb begin
    o_d = '0;
    for (int k = 0; k < channels; k++)
      if (gnt[k])
        o_d = i_d[k*width +: width];
  end

  always_ff @(posedge clk) begin
    if (reset)
      o_err <= 1'b0;
    else if (|ovf)
      o_err <= 1'b1;
  end

endmodule
